// File: rtl/pong_pkg.sv
// Shared constants for the score display path.
// Digit-box indices, glyph geometry and the blank code.
package pong_pkg;

  localparam logic [4:0] BLANK_CODE = 5'd15;

  localparam int GLYPH_COLS = 3;
  localparam int GLYPH_ROWS = 5;

  localparam int P1T = 0;
  localparam int P1U = 1;
  localparam int P2T = 2;
  localparam int P2U = 3;

  // A zero tens digit is shown as blank.
  function automatic logic [4:0] tens_code(input logic [3:0] t);
    return (t == 4'd0) ? BLANK_CODE : {1'b0, t};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter.
// Saturates at 99; clear wins over inc.
module bcd_score_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic at_max;

  assign at_max = (tens == 4'd9) && (units == 4'd9);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clear) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc && !at_max) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_digit_scanner.sv
// Score keeping plus pixel-to-glyph mapping for four digit boxes.
// Two-stage pipeline from pix_x/pix_y to number/position/active.
module score_digit_scanner
  import pong_pkg::*;
#(
  parameter int SCALE_LOG2 = 3,
  parameter int P1_X       = 240,
  parameter int P2_X       = 360,
  parameter int DIGIT_Y    = 32,
  parameter int WIN_SCORE  = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       p1_goal,
  input  logic       p2_goal,
  input  logic       clear,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [4:0] number,
  output logic [4:0] position,
  output logic       active,
  output logic       game_over
);

  localparam int S  = 1 << SCALE_LOG2;
  localparam int BW = GLYPH_COLS * S;
  localparam int BH = GLYPH_ROWS * S;

  function automatic int org(input int b);
    case (b)
      P1T:     return P1_X;
      P1U:     return P1_X + 4 * S;
      P2T:     return P2_X;
      default: return P2_X + 4 * S;
    endcase
  endfunction

  logic [3:0] l1t, l1u, l2t, l2u;
  logic [3:0] d1t, d1u, d2t, d2u;
  logic [6:0] v1, v2;

  bcd_score_counter u_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (p1_goal & ~game_over),
    .tens    (l1t),
    .units   (l1u)
  );

  bcd_score_counter u_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (p2_goal & ~game_over),
    .tens    (l2t),
    .units   (l2u)
  );

  assign v1 = 7'(l1t) * 7'd10 + 7'(l1u);
  assign v2 = 7'(l2t) * 7'd10 + 7'(l2u);

  always_ff @(posedge clk) begin
    if (!reset_n)
      game_over <= 1'b0;
    else if (clear)
      game_over <= 1'b0;
    else if (v1 >= 7'(WIN_SCORE) || v2 >= 7'(WIN_SCORE))
      game_over <= 1'b1;
  end

  // Display copy only moves at frame start to avoid tearing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d1t <= '0;
      d1u <= '0;
      d2t <= '0;
      d2u <= '0;
    end else if (frame_tick) begin
      d1t <= l1t;
      d1u <= l1u;
      d2t <= l2t;
      d2u <= l2u;
    end
  end

  logic [10:0] px, py;
  logic        yin;
  logic [3:0]  inb, hit;
  logic [1:0]  col;
  logic [2:0]  row;

  assign px  = {1'b0, pix_x};
  assign py  = {1'b0, pix_y};
  assign yin = (py >= 11'(DIGIT_Y)) && (py < 11'(DIGIT_Y + BH));
  assign row = 3'((py - 11'(DIGIT_Y)) >> SCALE_LOG2);

  always_comb begin
    inb = '0;
    for (int b = 0; b < 4; b++)
      inb[b] = yin && (px >= 11'(org(b))) && (px < 11'(org(b) + BW));
  end

  // Walk high to low so the lowest box index wins on overlap.
  always_comb begin
    hit = '0;
    col = '0;
    for (int b = 3; b >= 0; b--) begin
      if (inb[b]) begin
        hit    = '0;
        hit[b] = 1'b1;
        col    = 2'((px - 11'(org(b))) >> SCALE_LOG2);
      end
    end
  end

  logic [3:0] s1_hit;
  logic [1:0] s1_col;
  logic [2:0] s1_row;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_hit <= '0;
      s1_col <= '0;
      s1_row <= '0;
    end else begin
      s1_hit <= hit;
      s1_col <= col;
      s1_row <= row;
    end
  end

  logic [4:0] nx_num, nx_pos;

  always_comb begin
    nx_num = BLANK_CODE;
    unique case (1'b1)
      s1_hit[P1T]: nx_num = tens_code(d1t);
      s1_hit[P1U]: nx_num = {1'b0, d1u};
      s1_hit[P2T]: nx_num = tens_code(d2t);
      s1_hit[P2U]: nx_num = {1'b0, d2u};
      default:     nx_num = BLANK_CODE;
    endcase
  end

  always_comb begin
    nx_pos = '0;
    if (|s1_hit)
      nx_pos = ({2'b0, s1_row} << 1) + {2'b0, s1_row} + {3'b0, s1_col};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      number   <= BLANK_CODE;
      position <= '0;
      active   <= 1'b0;
    end else begin
      number   <= nx_num;
      position <= nx_pos;
      active   <= |s1_hit;
    end
  end

endmodule

// File: tb/tb_score_digit_scanner.sv
// Bench for score_digit_scanner: two instances (win at 11 and 99)
// against a score/geometry model, plus directed literal checks.
module tb_score_digit_scanner;

  localparam int S = 8;
  localparam int DY = 32;
  localparam int WIN [2] = '{11, 99};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_goal = 1'b0;
  logic       p2_goal = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;

  logic [4:0] num0, pos0, num1, pos1;
  logic       act0, act1, go0, go1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  score_digit_scanner #(.WIN_SCORE(11)) dut0 (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .p1_goal(p1_goal), .p2_goal(p2_goal), .clear(clear),
    .pix_x(pix_x), .pix_y(pix_y),
    .number(num0), .position(pos0), .active(act0), .game_over(go0)
  );

  score_digit_scanner #(.WIN_SCORE(99)) dut1 (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .p1_goal(p1_goal), .p2_goal(p2_goal), .clear(clear),
    .pix_x(pix_x), .pix_y(pix_y),
    .number(num1), .position(pos1), .active(act1), .game_over(go1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Pure geometry + score rule: what one pixel should show.
  task automatic glyph(input int x, input int y, input int sc0, input int sc1,
                       output int n, output int p, output int a);
    int ox [4];
    ox = '{240, 240 + 4 * S, 360, 360 + 4 * S};
    n = 15; p = 0; a = 0;
    for (int b = 3; b >= 0; b--) begin
      if (x >= ox[b] && x < ox[b] + 3 * S && y >= DY && y < DY + 5 * S) begin
        int sc, v;
        sc = (b < 2) ? sc0 : sc1;
        v  = (b % 2 == 0) ? sc / 10 : sc % 10;
        n  = (b % 2 == 0 && v == 0) ? 15 : v;
        p  = 3 * ((y - DY) / S) + (x - ox[b]) / S;
        a  = 1;
      end
    end
  endtask

  int  ms [2][2];
  int  md [2][2];
  bit  mgo [2];
  int  en [2], ep [2], ea [2], eg [2];
  int  ppx, ppy;
  bit  pv = 0;
  bit  mon = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        ms[i] = '{0, 0}; md[i] = '{0, 0}; mgo[i] = 0;
        en[i] = 15; ep[i] = 0; ea[i] = 0; eg[i] = 0;
      end
      pv = 0;
      mon = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ng;
        if (pv) glyph(ppx, ppy, md[i][0], md[i][1], en[i], ep[i], ea[i]);
        else begin en[i] = 15; ep[i] = 0; ea[i] = 0; end
        ng = mgo[i] || ms[i][0] >= WIN[i] || ms[i][1] >= WIN[i];
        if (clear) ng = 0;
        if (frame_tick) md[i] = ms[i];
        if (clear) ms[i] = '{0, 0};
        else if (!mgo[i]) begin
          if (p1_goal && ms[i][0] < 99) ms[i][0]++;
          if (p2_goal && ms[i][1] < 99) ms[i][1]++;
        end
        mgo[i] = ng;
        eg[i] = int'(ng);
      end
      pv = 1; ppx = int'(pix_x); ppy = int'(pix_y);
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("num0", int'(num0), en[0]);
      chk("pos0", int'(pos0), ep[0]);
      chk("act0", int'(act0), ea[0]);
      chk("go0",  int'(go0),  eg[0]);
      chk("num1", int'(num1), en[1]);
      chk("pos1", int'(pos1), ep[1]);
      chk("act1", int'(act1), ea[1]);
      chk("go1",  int'(go1),  eg[1]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe(input int x, input int y);
    pix_x = 10'(x); pix_y = 10'(y);
    tick(2);
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_num", int'(num0), 15);
    chk("rst_act", int'(act0), 0);
    chk("rst_go",  int'(go0), 0);
    reset_n = 1'b1;

    probe(240, 32);
    chk("t1_p1t_act", int'(act0), 1);
    chk("t1_p1t_num", int'(num0), 15);
    chk("t1_p1t_pos", int'(pos0), 0);
    probe(272, 32);
    chk("t1_p1u_num", int'(num0), 0);
    chk("t1_p1u_pos", int'(pos0), 0);

    p1_goal = 1'b1; tick(3); p1_goal = 1'b0;
    probe(289, 49);
    chk("t2_pre_num", int'(num0), 0);
    pulse_frame();
    probe(289, 49);
    chk("t2_num", int'(num0), 3);
    chk("t2_pos", int'(pos0), 8);

    do_clear();
    p1_goal = 1'b1; p2_goal = 1'b1; tick(10);
    p1_goal = 1'b0; p2_goal = 1'b0;
    pulse_frame();
    probe(240, 32); chk("t3_p1t", int'(num0), 1);
    probe(272, 32); chk("t3_p1u", int'(num0), 0);
    probe(360, 32); chk("t3_p2t", int'(num0), 1);
    probe(392, 32); chk("t3_p2u", int'(num0), 0);

    do_clear();
    p2_goal = 1'b1; tick(11); p2_goal = 1'b0;
    chk("t4_go_lag", int'(go0), 0);
    tick();
    chk("t4_go", int'(go0), 1);
    p2_goal = 1'b1; tick(); p2_goal = 1'b0;
    pulse_frame();
    probe(392, 32); chk("t4_p2u_hold", int'(num0), 1);
    probe(360, 32); chk("t4_p2t_hold", int'(num0), 1);
    do_clear();
    chk("t4_go_clr", int'(go0), 0);
    clear = 1'b1; p1_goal = 1'b1; tick();
    clear = 1'b0; p1_goal = 1'b0;
    pulse_frame();
    probe(272, 32); chk("t4_clr_pri", int'(num0), 0);
    probe(392, 32); chk("t4_p2_zero", int'(num0), 0);

    p1_goal = 1'b1; tick(100); p1_goal = 1'b0;
    pulse_frame();
    probe(240, 32); chk("t5_sat_t", int'(num1), 9);
    probe(272, 32); chk("t5_sat_u", int'(num1), 9);
    probe(263, 32);
    chk("t5_edge_act", int'(act1), 1);
    chk("t5_edge_pos", int'(pos1), 2);
    probe(264, 32);
    chk("t5_out_act", int'(act1), 0);
    chk("t5_out_num", int'(num1), 15);

    probe(240, 32);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("t6_act", int'(act0), 0);
    chk("t6_num", int'(num0), 15);
    chk("t6_go",  int'(go0), 0);
    tick();
    probe(272, 32); chk("t6_score", int'(num1), 0);

    for (int c = 0; c < 4000; c++) begin
      pix_x      = 10'(230 + $urandom_range(0, 190));
      pix_y      = 10'($urandom_range(25, 80));
      p1_goal    = ($urandom_range(0, 5) == 0);
      p2_goal    = ($urandom_range(0, 5) == 0);
      clear      = ($urandom_range(0, 149) == 0);
      frame_tick = ($urandom_range(0, 29) == 0);
      reset_n    = ($urandom_range(0, 599) != 0);
      tick();
    end
    reset_n = 1'b1; p1_goal = 1'b0; p2_goal = 1'b0;
    clear = 1'b0; frame_tick = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
